// File: rtl/env_write_sched.sv
// env_write_sched: serialises agent deposits and periodic decay sweeps onto a
// single read-modify-write port of the environment cell array.
module env_write_sched #(
  parameter int unsigned X_bits      = 10,
  parameter int unsigned Y_bits      = 9,
  parameter int unsigned SIGNAL_bits = 4,
  parameter int unsigned PIXELS_X    = 640,
  parameter int unsigned PIXELS_Y    = 480,
  parameter int unsigned DECAY_STEP  = 1
) (
  input  logic                   newLocClock,
  input  logic                   RESET_SIM,
  input  logic                   dep_valid,
  output logic                   dep_ready,
  input  logic [X_bits-1:0]      dep_X,
  input  logic [Y_bits-1:0]      dep_Y,
  input  logic [SIGNAL_bits-1:0] dep_signal,
  input  logic                   dep_take,
  input  logic                   decay_tick,
  output logic [X_bits-1:0]      lookup_X,
  output logic [Y_bits-1:0]      lookup_Y,
  input  logic [SIGNAL_bits:0]   lookup_data,
  output logic                   write_en,
  output logic [X_bits-1:0]      write_X,
  output logic [Y_bits-1:0]      write_Y,
  output logic [SIGNAL_bits-1:0] write_signal,
  output logic                   write_sugar,
  output logic                   sweep_busy,
  output logic                   decay_overrun
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DEP_RD = 3'd1;
  localparam logic [2:0] S_DEP_WR = 3'd2;
  localparam logic [2:0] S_SWP_RD = 3'd3;
  localparam logic [2:0] S_SWP_WR = 3'd4;

  localparam logic [SIGNAL_bits-1:0] SIG_MAX = '1;
  localparam logic [SIGNAL_bits-1:0] DECAY   = SIGNAL_bits'(DECAY_STEP);
  localparam logic [X_bits-1:0]      X_LAST  = X_bits'(PIXELS_X - 1);
  localparam logic [Y_bits-1:0]      Y_LAST  = Y_bits'(PIXELS_Y - 1);

  logic [2:0]             state_q, state_d;
  logic [X_bits-1:0]      cap_x_q, cap_x_d;
  logic [Y_bits-1:0]      cap_y_q, cap_y_d;
  logic [SIGNAL_bits-1:0] cap_sig_q, cap_sig_d;
  logic                   cap_take_q, cap_take_d;
  logic                   cap_drop_q, cap_drop_d;
  logic [X_bits-1:0]      cur_x_q, cur_x_d;
  logic [Y_bits-1:0]      cur_y_q, cur_y_d;
  logic [X_bits-1:0]      lookup_x_q, lookup_x_d;
  logic [Y_bits-1:0]      lookup_y_q, lookup_y_d;
  logic                   write_en_q, write_en_d;
  logic [X_bits-1:0]      write_x_q, write_x_d;
  logic [Y_bits-1:0]      write_y_q, write_y_d;
  logic [SIGNAL_bits-1:0] write_sig_q, write_sig_d;
  logic                   write_sugar_q, write_sugar_d;
  logic                   sweep_busy_q, sweep_busy_d;   // sweep pending or in progress
  logic                   sweep_turn_q, sweep_turn_d;
  logic                   overrun_q, overrun_d;

  logic [SIGNAL_bits-1:0] lk_sig;
  logic                   lk_sugar;
  logic [SIGNAL_bits:0]   sat_sum;
  logic [SIGNAL_bits-1:0] dec_sig;

  // Deposits are offered only from IDLE and only when it is not the sweep's turn
  assign dep_ready = (state_q == S_IDLE) && !sweep_turn_q;

  // Next-state, arbitration and read-modify-write datapath
  always_comb begin
    state_d       = state_q;
    cap_x_d       = cap_x_q;
    cap_y_d       = cap_y_q;
    cap_sig_d     = cap_sig_q;
    cap_take_d    = cap_take_q;
    cap_drop_d    = cap_drop_q;
    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    lookup_x_d    = lookup_x_q;
    lookup_y_d    = lookup_y_q;
    write_en_d    = 1'b0;
    write_x_d     = write_x_q;
    write_y_d     = write_y_q;
    write_sig_d   = write_sig_q;
    write_sugar_d = write_sugar_q;
    sweep_busy_d  = sweep_busy_q;
    sweep_turn_d  = sweep_turn_q;
    overrun_d     = overrun_q;

    lk_sig   = lookup_data[SIGNAL_bits:1];
    lk_sugar = lookup_data[0];
    sat_sum  = {1'b0, lk_sig} + {1'b0, cap_sig_q};
    dec_sig  = (lk_sig > DECAY) ? (lk_sig - DECAY) : '0;

    if (decay_tick) begin
      if (sweep_busy_q) overrun_d = 1'b1;
      else              sweep_busy_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (dep_valid && dep_ready) begin
          cap_x_d    = dep_X;
          cap_y_d    = dep_Y;
          cap_sig_d  = dep_signal;
          cap_take_d = dep_take;
          cap_drop_d = (32'(dep_X) >= 32'(PIXELS_X)) || (32'(dep_Y) >= 32'(PIXELS_Y));
          lookup_x_d = dep_X;
          lookup_y_d = dep_Y;
          state_d    = S_DEP_RD;
        end else if (sweep_busy_q) begin
          lookup_x_d = cur_x_q;
          lookup_y_d = cur_y_q;
          state_d    = S_SWP_RD;
        end
      end
      S_DEP_RD: begin
        state_d = S_DEP_WR;
        if (!cap_drop_q) begin
          write_en_d    = 1'b1;
          write_x_d     = cap_x_q;
          write_y_d     = cap_y_q;
          write_sig_d   = sat_sum[SIGNAL_bits] ? SIG_MAX : sat_sum[SIGNAL_bits-1:0];
          write_sugar_d = lk_sugar & ~cap_take_q;
        end
      end
      S_DEP_WR: begin
        state_d      = S_IDLE;
        sweep_turn_d = sweep_busy_q;
      end
      S_SWP_RD: begin
        state_d       = S_SWP_WR;
        write_en_d    = 1'b1;
        write_x_d     = cur_x_q;
        write_y_d     = cur_y_q;
        write_sig_d   = dec_sig;
        write_sugar_d = lk_sugar;
      end
      S_SWP_WR: begin
        state_d      = S_IDLE;
        sweep_turn_d = 1'b0;
        if (cur_x_q == X_LAST) begin
          cur_x_d = '0;
          if (cur_y_q == Y_LAST) begin
            cur_y_d      = '0;
            sweep_busy_d = 1'b0;
          end else begin
            cur_y_d = cur_y_q + Y_bits'(1);
          end
        end else begin
          cur_x_d = cur_x_q + X_bits'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge newLocClock or negedge RESET_SIM) begin
    if (!RESET_SIM) begin
      state_q       <= S_IDLE;
      cap_x_q       <= '0;
      cap_y_q       <= '0;
      cap_sig_q     <= '0;
      cap_take_q    <= 1'b0;
      cap_drop_q    <= 1'b0;
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      lookup_x_q    <= '0;
      lookup_y_q    <= '0;
      write_en_q    <= 1'b0;
      write_x_q     <= '0;
      write_y_q     <= '0;
      write_sig_q   <= '0;
      write_sugar_q <= 1'b0;
      sweep_busy_q  <= 1'b0;
      sweep_turn_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cap_x_q       <= cap_x_d;
      cap_y_q       <= cap_y_d;
      cap_sig_q     <= cap_sig_d;
      cap_take_q    <= cap_take_d;
      cap_drop_q    <= cap_drop_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      lookup_x_q    <= lookup_x_d;
      lookup_y_q    <= lookup_y_d;
      write_en_q    <= write_en_d;
      write_x_q     <= write_x_d;
      write_y_q     <= write_y_d;
      write_sig_q   <= write_sig_d;
      write_sugar_q <= write_sugar_d;
      sweep_busy_q  <= sweep_busy_d;
      sweep_turn_q  <= sweep_turn_d;
      overrun_q     <= overrun_d;
    end
  end

  assign lookup_X      = lookup_x_q;
  assign lookup_Y      = lookup_y_q;
  assign write_en      = write_en_q;
  assign write_X       = write_x_q;
  assign write_Y       = write_y_q;
  assign write_signal  = write_sig_q;
  assign write_sugar   = write_sugar_q;
  assign sweep_busy    = sweep_busy_q;
  assign decay_overrun = overrun_q;

endmodule

// File: tb/tb_env_write_sched.sv
// Directed bench for env_write_sched: a 4x3 instance for deposits/overrun/reset
// and a 2x2 instance for sweep order and deposit/sweep alternation.
module tb_env_write_sched;

  typedef struct {int x; int y; int s; int g;} wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic mem_init_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // Instance A (4x3)
  logic       dva, tka, dta, rdy_a, wea, wsg_a, busy_a, ovr_a;
  logic [9:0] dxa, lxa, wxa;
  logic [8:0] dya, lya, wya;
  logic [3:0] dsa, wsa;
  logic [4:0] lda;
  logic [4:0] mem_a [12];
  wr_t        log_a [$];

  // Instance B (2x2)
  logic       dvb, tkb, dtb, rdy_b, web, wsg_b, busy_b, ovr_b;
  logic [9:0] dxb, lxb, wxb;
  logic [8:0] dyb, lyb, wyb;
  logic [3:0] dsb, wsb;
  logic [4:0] ldb;
  logic [4:0] mem_b [4];
  wr_t        log_b [$];

  env_write_sched #(.X_bits(10), .Y_bits(9), .SIGNAL_bits(4), .PIXELS_X(4), .PIXELS_Y(3), .DECAY_STEP(1)) u_a (
    .newLocClock(clk), .RESET_SIM(rst_n), .dep_valid(dva), .dep_ready(rdy_a), .dep_X(dxa), .dep_Y(dya),
    .dep_signal(dsa), .dep_take(dta), .decay_tick(tka), .lookup_X(lxa), .lookup_Y(lya), .lookup_data(lda),
    .write_en(wea), .write_X(wxa), .write_Y(wya), .write_signal(wsa), .write_sugar(wsg_a),
    .sweep_busy(busy_a), .decay_overrun(ovr_a));

  env_write_sched #(.X_bits(10), .Y_bits(9), .SIGNAL_bits(4), .PIXELS_X(2), .PIXELS_Y(2), .DECAY_STEP(1)) u_b (
    .newLocClock(clk), .RESET_SIM(rst_n), .dep_valid(dvb), .dep_ready(rdy_b), .dep_X(dxb), .dep_Y(dyb),
    .dep_signal(dsb), .dep_take(dtb), .decay_tick(tkb), .lookup_X(lxb), .lookup_Y(lyb), .lookup_data(ldb),
    .write_en(web), .write_X(wxb), .write_Y(wyb), .write_signal(wsb), .write_sugar(wsg_b),
    .sweep_busy(busy_b), .decay_overrun(ovr_b));

  // Environment models: combinational read, write committed at the clock edge
  always_comb begin
    lda = 5'd0;
    ldb = 5'd0;
    if (lxa < 10'd4 && lya < 9'd3) lda = mem_a[int'(lya) * 4 + int'(lxa)];
    if (lxb < 10'd2 && lyb < 9'd2) ldb = mem_b[int'(lyb) * 2 + int'(lxb)];
  end

  always @(posedge clk) begin
    wr_t e;
    if (!mem_init_n) begin
      for (int i = 0; i < 12; i++) mem_a[i] <= 5'd0;
      mem_a[11] <= {4'd5, 1'b1};   // (3,2)
      mem_a[5]  <= {4'd14, 1'b1};  // (1,1)
      mem_b[0]  <= {4'd0, 1'b1};
      mem_b[1]  <= {4'd3, 1'b0};
      mem_b[2]  <= {4'd3, 1'b1};
      mem_b[3]  <= {4'd1, 1'b0};
    end else begin
      if (wea && wxa < 10'd4 && wya < 9'd3) begin
        mem_a[int'(wya) * 4 + int'(wxa)] <= {wsa, wsg_a};
        e.x = int'(wxa); e.y = int'(wya); e.s = int'(wsa); e.g = int'(wsg_a);
        log_a.push_back(e);
      end
      if (web && wxb < 10'd2 && wyb < 9'd2) begin
        mem_b[int'(wyb) * 2 + int'(wxb)] <= {wsb, wsg_b};
        e.x = int'(wxb); e.y = int'(wyb); e.s = int'(wsb); e.g = int'(wsg_b);
        log_b.push_back(e);
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_wr(input string tag, input wr_t e, input int x, input int y, input int s, input int g);
    check({tag, ".x"}, e.x, x);
    check({tag, ".y"}, e.y, y);
    check({tag, ".sig"}, e.s, s);
    check({tag, ".sugar"}, e.g, g);
  endtask

  // Offer one deposit on instance A; returns at the negedge after acceptance
  task automatic dep_a(input int x, input int y, input int s, input int t);
    int n = 0;
    while (rdy_a !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("dep_a_ready", int'(rdy_a), 1);
    dva = 1'b1; dxa = 10'(x); dya = 9'(y); dsa = 4'(s); dta = 1'(t);
    @(negedge clk);
    dva = 1'b0;
  endtask

  task automatic wait_idle_a(input string tag);
    int n = 0;
    while (busy_a !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, int'(busy_a), 0);
  endtask

  initial begin
    int n0;
    int n;
    dva = 0; tka = 0; dta = 0; dxa = '0; dya = '0; dsa = '0;
    dvb = 0; tkb = 0; dtb = 0; dxb = '0; dyb = '0; dsb = '0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_dep_ready", int'(rdy_a), 1);
    check("rst_write_en", int'(wea), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_overrun", int'(ovr_a), 0);
    check("rst_lookup_x", int'(lxa), 0);
    check("rst_write_sig", int'(wsa), 0);
    repeat (2) @(negedge clk);
    mem_init_n = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    // (3,2)={5,1} + 4, no take -> 9, sugar kept
    dep_a(3, 2, 4, 0);
    check("d1_rd_we", int'(wea), 0);
    check("d1_lookup_x", int'(lxa), 3);
    check("d1_lookup_y", int'(lya), 2);
    @(negedge clk);
    check("d1_we", int'(wea), 1);
    check("d1_wx", int'(wxa), 3);
    check("d1_wy", int'(wya), 2);
    check("d1_sig", int'(wsa), 9);
    check("d1_sugar", int'(wsg_a), 1);
    @(negedge clk);
    check("d1_we_off", int'(wea), 0);
    check("d1_sig_hold", int'(wsa), 9);

    // Immediate re-deposit to the same cell sees the committed 9
    dep_a(3, 2, 2, 0);
    @(negedge clk);
    check("raw_sig", int'(wsa), 11);

    // (1,1)={14,1} + 5 with take -> saturate at 15, sugar cleared
    dep_a(1, 1, 5, 1);
    @(negedge clk);
    check("sat_we", int'(wea), 1);
    check("sat_sig", int'(wsa), 15);
    check("sat_sugar", int'(wsg_a), 0);
    @(negedge clk);

    // Out-of-range deposits are accepted but never written
    n0 = log_a.size();
    dep_a(4, 0, 3, 0);
    check("oob_x_we0", int'(wea), 0);
    @(negedge clk);
    check("oob_x_we1", int'(wea), 0);
    check("oob_wx_hold", int'(wxa), 1);
    dep_a(0, 3, 1, 0);
    @(negedge clk);
    @(negedge clk);
    check("oob_writes", log_a.size(), n0);

    // Full sweep of A with an overrunning second tick
    n0 = log_a.size();
    tka = 1'b1;
    @(negedge clk);
    tka = 1'b0;
    check("swp_busy", int'(busy_a), 1);
    check("swp_ovr0", int'(ovr_a), 0);
    tka = 1'b1;
    @(negedge clk);
    tka = 1'b0;
    check("swp_ovr1", int'(ovr_a), 1);
    wait_idle_a("swp_a_done");
    check("swp_a_writes", log_a.size() - n0, 12);
    if (log_a.size() >= n0 + 12) begin
      check_wr("swp_a_first", log_a[n0], 0, 0, 0, 0);
      check_wr("swp_a_last", log_a[n0 + 11], 3, 2, 10, 1);
    end
    check("swp_a_cell11", int'(mem_a[5]), 14 * 2 + 0);
    check("swp_a_ovr_sticky", int'(ovr_a), 1);

    // 2x2 sweep order and decay values
    tkb = 1'b1;
    @(negedge clk);
    tkb = 1'b0;
    n = 0;
    while (busy_b !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("swp_b_done", int'(busy_b), 0);
    check("swp_b_writes", log_b.size(), 4);
    if (log_b.size() >= 4) begin
      check_wr("swp_b0", log_b[0], 0, 0, 0, 1);
      check_wr("swp_b1", log_b[1], 1, 0, 2, 0);
      check_wr("swp_b2", log_b[2], 0, 1, 2, 1);
      check_wr("swp_b3", log_b[3], 1, 1, 0, 0);
    end

    // Deposit held valid across a sweep; tick on the same edge as acceptance
    dvb = 1'b1; dxb = 10'd1; dyb = 9'd1; dsb = 4'd1; dtb = 1'b0; tkb = 1'b1;
    @(negedge clk);
    tkb = 1'b0;
    n = 0;
    while (busy_b !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    dvb = 1'b0;
    check("alt_done", int'(busy_b), 0);
    repeat (4) @(negedge clk);
    check("alt_writes", log_b.size(), 12);
    if (log_b.size() >= 12) begin
      check_wr("alt_d1", log_b[4], 1, 1, 1, 0);
      check_wr("alt_s1", log_b[5], 0, 0, 0, 1);
      check_wr("alt_d2", log_b[6], 1, 1, 2, 0);
      check_wr("alt_s2", log_b[7], 1, 0, 1, 0);
      check_wr("alt_d3", log_b[8], 1, 1, 3, 0);
      check_wr("alt_s3", log_b[9], 0, 1, 1, 1);
      check_wr("alt_d4", log_b[10], 1, 1, 4, 0);
      check_wr("alt_s4", log_b[11], 1, 1, 3, 0);
    end

    // Reset asserted while A sits in SWP_RD
    tka = 1'b1;
    @(negedge clk);
    tka = 1'b0;
    @(negedge clk);
    check("rr_in_swp_rd_we", int'(wea), 0);
    check("rr_lookup_x", int'(lxa), 0);
    n0 = log_a.size();
    #1 rst_n = 1'b0;
    #1;
    check("rr_write_en", int'(wea), 0);
    check("rr_busy", int'(busy_a), 0);
    check("rr_overrun", int'(ovr_a), 0);
    check("rr_write_x", int'(wxa), 0);
    check("rr_write_y", int'(wya), 0);
    check("rr_write_sig", int'(wsa), 0);
    check("rr_write_sugar", int'(wsg_a), 0);
    check("rr_dep_ready", int'(rdy_a), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rr_no_writes", log_a.size(), n0);
    check("rr_idle_busy", int'(busy_a), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/env_write_sched.md
ENV_WRITE_SCHED -- requirements
Module: env_write_sched

Interface
REQ-001 SHALL take parameter X_bits, default 10, width of column index.
REQ-002 SHALL take parameter Y_bits, default 9, width of row index.
REQ-003 SHALL take parameter SIGNAL_bits, default 4, width of pheromone signal field.
REQ-004 SHALL take parameter PIXELS_X, default 640, columns per row.
REQ-005 SHALL take parameter PIXELS_Y, default 480, number of rows.
REQ-006 SHALL take parameter DECAY_STEP, default 1, signal decrement per sweep.
REQ-007 SHALL have port newLocClock  in  1  sole clock; all state on rising edge.
REQ-008 SHALL have port RESET_SIM  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have ports dep_valid in 1 / dep_ready out 1, deposit handshake.
REQ-010 SHALL have ports dep_X in X_bits, dep_Y in Y_bits, deposit cell coordinate.
REQ-011 SHALL have ports dep_signal in SIGNAL_bits (amount to add) and dep_take in 1 (1 = clear sugar).
REQ-012 SHALL have port decay_tick  in  1  one-cycle pulse requesting a full decay sweep.
REQ-013 SHALL have ports lookup_X out X_bits, lookup_Y out Y_bits, lookup_data in SIGNAL_bits+1 ({signal,sugar}, combinational from env rows).
REQ-014 SHALL have ports write_en out 1, write_X out X_bits, write_Y out Y_bits, write_signal out SIGNAL_bits, write_sugar out 1 (row decode of write_Y+write_en is external).
REQ-015 SHALL have ports sweep_busy out 1 and decay_overrun out 1 (sticky).

Function
REQ-016 SHALL implement FSM states IDLE, DEP_RD, DEP_WR, SWP_RD, SWP_WR; one state per cycle outside IDLE.
REQ-017 SHALL assert dep_ready only in IDLE and not when sweep_turn=1; a deposit is accepted on an edge with dep_valid&dep_ready.
REQ-018 SHALL on acceptance capture dep_X/Y/signal/take and go DEP_RD; DEP_RD drives lookup_X/Y=captured coordinate and registers lookup_data; then DEP_WR.
REQ-019 SHALL in DEP_WR assert write_en for exactly that cycle with write_signal=min(old_signal+dep_signal, 2^SIGNAL_bits-1), write_sugar=old_sugar & ~dep_take; then IDLE.
REQ-020 SHALL drop (no write_en, FSM still traverses DEP_RD/DEP_WR) any deposit with dep_X>=PIXELS_X or dep_Y>=PIXELS_Y.
REQ-021 SHALL set sweep_pending on decay_tick while no sweep active; a tick while sweep_busy=1 SHALL set decay_overrun and be otherwise ignored.
REQ-022 SHALL, in IDLE with sweep pending/active and no eligible deposit (or sweep_turn=1), process cursor cell via SWP_RD (lookup) then SWP_WR (write_en=1, write_signal=max(old_signal-DECAY_STEP,0), write_sugar=old_sugar).
REQ-023 SHALL advance cursor after each SWP_WR: X+1; at X=PIXELS_X-1 wrap X=0, Y+1; after (PIXELS_X-1,PIXELS_Y-1) return to (0,0) and end the sweep.
REQ-024 SHALL set sweep_turn=1 after a deposit completes while a sweep is active, and clear it after a sweep cell completes (strict alternation, no starvation).
REQ-025 SHALL hold sweep_busy=1 from the cycle after the starting tick until the cycle after the final SWP_WR.
REQ-026 SHALL keep write_en=0 and lookup/write buses stable (last values) in IDLE, DEP_RD, SWP_RD.
REQ-027 SHALL read-after-write correctly: a write committed at an edge is visible to the following RD state.
REQ-028 SHALL, for decay_tick and accepted deposit on the same edge, take the deposit first and start the sweep afterwards.

Reset
REQ-029 SHALL on RESET_SIM low immediately force: state IDLE, write_en=0, all address/data outputs 0, cursor (0,0), sweep_pending=0, sweep_turn=0, sweep_busy=0, decay_overrun=0; dep_ready=1.
REQ-030 SHALL, on reset mid-operation, abandon any in-flight deposit or sweep with no further write_en.

Verification
REQ-031 SHALL cover: cell (3,2)={5,1}, deposit X=3 Y=2 signal=4 take=0 -> write_en 2 cycles after accept, write_signal=9, write_sugar=1.
REQ-032 SHALL cover: cell {14,1}, deposit signal=5 take=1 -> write_signal=15 (saturated), write_sugar=0.
REQ-033 SHALL cover: decay_tick with no deposits, 2x2 grid params -> 4 writes at (0,0),(1,0),(0,1),(1,1), signal 0 stays 0, 3 stays 2, sweep_busy drops, cursor back to (0,0).
REQ-034 SHALL cover: dep_valid held high during sweep -> deposit and sweep writes alternate; sweep completes.
REQ-035 SHALL cover: deposit X=PIXELS_X -> accepted, no write_en; second decay_tick during sweep -> decay_overrun=1 until reset.
REQ-036 SHALL cover: RESET_SIM low during SWP_RD -> no write_en, outputs per REQ-029 without waiting for clock.
